// File: rtl/spatial_encoder_param.sv
// spatial_encoder_param: multi-modality HD spatial encoder with per-modality majority bundling and cross-modality fusion
module spatial_encoder_param #(
   parameter int HV_DIMENSION  = 2000,
   parameter int CHANNEL_WIDTH = 4,
   parameter int MOD1_CH       = 32,
   parameter int MOD2_CH       = 77,
   parameter int MOD3_CH       = 105,
   localparam int TOTAL_CH     = MOD1_CH + MOD2_CH + MOD3_CH,
   localparam int AW           = $clog2(TOTAL_CH)
) (
   input  logic                              Clk_CI,
   input  logic                              Reset_RI,
   input  logic                              ValidIn_SI,
   output logic                              ReadyOut_SO,
   input  logic [0:CHANNEL_WIDTH*TOTAL_CH-1] ChannelsInput_DI,
   input  logic [2:0]                        ModeEn_SI,
   output logic                              ValidOut_SO,
   input  logic                              ReadyIn_SI,
   output logic [2:0]                        SramReq_SO,
   input  logic [2:0]                        SramValid_SI,
   output logic [AW-1:0]                     Addr_mod1_DO,
   output logic [AW-1:0]                     Addr_mod2_DO,
   output logic [AW-1:0]                     Addr_mod3_DO,
   input  logic [3*HV_DIMENSION-1:0]         IM_DI,
   input  logic [3*HV_DIMENSION-1:0]         ProjNeg_DI,
   input  logic [3*HV_DIMENSION-1:0]         ProjPos_DI,
   output logic [HV_DIMENSION-1:0]           HypervectorOut_mod1_DO,
   output logic [HV_DIMENSION-1:0]           HypervectorOut_mod2_DO,
   output logic [HV_DIMENSION-1:0]           HypervectorOut_mod3_DO,
   output logic [HV_DIMENSION-1:0]           HypervectorFused_DO
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CHANNEL_WIDTH-1:0] feat_q [TOTAL_CH];
   logic [2:0] en_q, en_d, fin;
   logic all_fin_q, accept, done_entry;
   logic [AW-1:0] addr [3];
   logic [HV_DIMENSION-1:0] hv_d [3];
   logic [HV_DIMENSION-1:0] hv_o [3];
   logic [HV_DIMENSION-1:0] fused_q;

   assign accept     = state_q == IDLE && ValidIn_SI;
   assign done_entry = state_q == RUN && all_fin_q;
   assign en_d       = ModeEn_SI == 3'b000 ? 3'b111 : ModeEn_SI;

   // state register
   always_ff @(posedge Clk_CI) begin
      state_q <= Reset_RI ? IDLE : state_d;
   end

   // next state and handshake outputs
   always_comb begin
      state_d     = state_q;
      ReadyOut_SO = 1'b0;
      ValidOut_SO = 1'b0;
      case (state_q)
         IDLE: begin
            ReadyOut_SO = 1'b1;
            if (ValidIn_SI) state_d = RUN;
         end
         RUN: if (all_fin_q) state_d = DONE;
         DONE: begin
            ValidOut_SO = 1'b1;
            if (ReadyIn_SI) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // frame capture; all_fin_q delays DONE entry until the last beat has landed in the counters
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         en_q      <= '0;
         all_fin_q <= 1'b0;
         for (int k = 0; k < TOTAL_CH; k++) feat_q[k] <= '0;
      end else begin
         all_fin_q <= state_q == RUN && &fin;
         if (accept) begin
            en_q <= en_d;
            for (int k = 0; k < TOTAL_CH; k++) feat_q[k] <= ChannelsInput_DI[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
         end
      end
   end

   for (genvar m = 0; m < 3; m++) begin : g_mod
      localparam int N    = m == 0 ? MOD1_CH : m == 1 ? MOD2_CH : MOD3_CH;
      localparam int BASE = m == 0 ? 0 : m == 1 ? MOD1_CH : MOD1_CH + MOD2_CH;
      localparam int CNTW = $clog2(N + 1);
      logic [AW-1:0] c_q;
      logic fin_q, beat;
      logic [CNTW-1:0] cnt_q [HV_DIMENSION];
      logic [HV_DIMENSION-1:0] b, b0_q, b1_q, maj, hv_q;
      logic [CHANNEL_WIDTH-1:0] f;

      assign addr[m]       = AW'(BASE) + c_q;
      assign fin[m]        = fin_q;
      assign SramReq_SO[m] = state_q == RUN && en_q[m] && !fin_q;
      assign beat          = SramReq_SO[m] && SramValid_SI[m];
      assign f             = feat_q[addr[m]];
      assign b             = IM_DI[m*HV_DIMENSION +: HV_DIMENSION] ^ (f[CHANNEL_WIDTH-1] ? ProjPos_DI[m*HV_DIMENSION +: HV_DIMENSION] : ProjNeg_DI[m*HV_DIMENSION +: HV_DIMENSION]);
      assign hv_d[m]       = en_q[m] ? maj : '0;
      assign hv_o[m]       = hv_q;

      // channel counter, finish flag and per-bit vote counters; disabled modalities start finished
      always_ff @(posedge Clk_CI) begin
         if (Reset_RI || accept) begin
            c_q   <= '0;
            fin_q <= !Reset_RI && !en_d[m];
            for (int i = 0; i < HV_DIMENSION; i++) cnt_q[i] <= '0;
         end else if (beat) begin
            c_q   <= c_q == AW'(N - 1) ? c_q : c_q + 1'b1;
            fin_q <= c_q == AW'(N - 1);
            for (int i = 0; i < HV_DIMENSION; i++) cnt_q[i] <= cnt_q[i] + CNTW'(b[i]);
         end
      end

      // bound vectors of local channels 0 and 1 break ties for even channel counts
      always_ff @(posedge Clk_CI) begin
         if (Reset_RI) begin
            b0_q <= '0;
            b1_q <= '0;
         end else if (beat) begin
            if (c_q == '0) b0_q <= b;
            if (c_q == AW'(1)) b1_q <= b;
         end
      end

      // majority threshold per bit against the channel count
      always_comb begin
         maj = '0;
         for (int i = 0; i < HV_DIMENSION; i++)
            maj[i] = 2 * int'(cnt_q[i]) > N ? 1'b1 : 2 * int'(cnt_q[i]) == N && (b0_q[i] ^ b1_q[i]);
      end

      // per-modality result, held until the next DONE entry
      always_ff @(posedge Clk_CI) begin
         if (Reset_RI) hv_q <= '0;
         else if (done_entry) hv_q <= hv_d[m];
      end
   end

   // fused result: majority when all three are active, otherwise OR (disabled ones are zero)
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) fused_q <= '0;
      else if (done_entry) fused_q <= en_q == 3'b111 ? (hv_d[0] & hv_d[1]) | (hv_d[0] & hv_d[2]) | (hv_d[1] & hv_d[2]) : hv_d[0] | hv_d[1] | hv_d[2];
   end

   assign Addr_mod1_DO           = addr[0];
   assign Addr_mod2_DO           = addr[1];
   assign Addr_mod3_DO           = addr[2];
   assign HypervectorOut_mod1_DO = hv_o[0];
   assign HypervectorOut_mod2_DO = hv_o[1];
   assign HypervectorOut_mod3_DO = hv_o[2];
   assign HypervectorFused_DO    = fused_q;
endmodule

// File: tb/tb_spatial_encoder_param.sv
// tb_spatial_encoder_param: scoreboard bench for spatial_encoder_param with hand-computed frames
module tb_spatial_encoder_param;
   typedef struct packed { logic [15:0] m1, m2, m3, f; } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vin = 1'b0, rdy_out, vout, rdy_in = 1'b1;
   logic [0:47] ch_in = '0;
   logic [0:47] feats;
   logic [2:0] mode = 3'b111, req, svalid = 3'b111;
   logic [3:0] a1, a2, a3;
   logic [47:0] im, pn, pp;
   logic [15:0] hv1, hv2, hv3, hvf;
   logic [15:0] im_mem [16];
   logic [15:0] pn_mem [16];
   logic [15:0] pp_mem [16];
   exp_t sb [$];
   int checks = 0;
   int errors = 0;

   localparam exp_t E_A_ALL = '{16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF};
   localparam exp_t E_B_ALL = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h00FF};
   localparam exp_t E_A_010 = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
   localparam exp_t E_B_011 = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
   localparam exp_t E_B_101 = '{16'h0000, 16'h0000, 16'h00FF, 16'h00FF};

   spatial_encoder_param #(
      .HV_DIMENSION(16), .CHANNEL_WIDTH(4), .MOD1_CH(3), .MOD2_CH(4), .MOD3_CH(5)
   ) dut (
      .Clk_CI(clk), .Reset_RI(rst), .ValidIn_SI(vin), .ReadyOut_SO(rdy_out),
      .ChannelsInput_DI(ch_in), .ModeEn_SI(mode), .ValidOut_SO(vout), .ReadyIn_SI(rdy_in),
      .SramReq_SO(req), .SramValid_SI(svalid),
      .Addr_mod1_DO(a1), .Addr_mod2_DO(a2), .Addr_mod3_DO(a3),
      .IM_DI(im), .ProjNeg_DI(pn), .ProjPos_DI(pp),
      .HypervectorOut_mod1_DO(hv1), .HypervectorOut_mod2_DO(hv2),
      .HypervectorOut_mod3_DO(hv3), .HypervectorFused_DO(hvf)
   );

   always #5 clk = ~clk;

   always_comb begin
      im = {im_mem[a3], im_mem[a2], im_mem[a1]};
      pn = {pn_mem[a3], pn_mem[a2], pn_mem[a1]};
      pp = {pp_mem[a3], pp_mem[a2], pp_mem[a1]};
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // mem b=1 makes modality 1 bind to zero; mem b=0 binds it to all ones
   task automatic set_mem(input bit b);
      logic [15:0] imv [12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hF0F0, 16'h0F0F, 16'h0000, 16'hFF00, 16'h1111, 16'h0000, 16'h0F0F};
      logic [15:0] pnv [12] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h00FF, 16'hAAAA, 16'hF00F, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0FF0, 16'h0000};
      logic [15:0] ppv [12] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h00FF, 16'h0000, 16'hF00F, 16'h5555, 16'h000F, 16'h0000, 16'h1E1E, 16'hFFFF, 16'hFFFF};
      for (int k = 0; k < 16; k++) begin
         im_mem[k] = k < 12 ? imv[k] : 16'h0;
         pn_mem[k] = k < 12 ? pnv[k] : 16'h0;
         pp_mem[k] = k < 12 ? ppv[k] : 16'h0;
      end
      if (b) for (int k = 0; k < 3; k++) begin
         pn_mem[k] = 16'h0000;
         pp_mem[k] = 16'h0000;
      end
   endtask

   // waits for IDLE, issues one frame, optionally checks request pattern and latency
   task automatic send(input logic [2:0] mask, input exp_t e, input int lat, input bit push);
      int n;
      logic [2:0] seen, eff;
      n = 0;
      while (rdy_out !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("ready_before_frame", 16'(rdy_out), 16'd1);
      vin = 1'b1;
      mode = mask;
      ch_in = feats;
      if (push) sb.push_back(e);
      @(posedge clk); #1;
      vin = 1'b0;
      if (lat > 0) begin
         eff = mask == 3'b000 ? 3'b111 : mask;
         chk("req_after_accept", 16'(req), 16'(eff));
         seen = '0;
         n = 0;
         while (vout !== 1'b1 && n < 50) begin seen |= req; @(posedge clk); #1; n++; end
         chk("latency", 16'(n), 16'(lat));
         chk("req_mask", 16'(seen), 16'(eff));
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (rdy_out !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
      chk("wait_idle", 16'(rdy_out), 16'd1);
   endtask

   // monitor: compares every accepted output against the scoreboard head
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (vout === 1'b1 && rdy_in === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output fused=%h t=%0t", hvf, $time);
            end else begin
               e = sb.pop_front();
               chk("out_mod1", hv1, e.m1);
               chk("out_mod2", hv2, e.m2);
               chk("out_mod3", hv3, e.m3);
               chk("out_fused", hvf, e.f);
            end
         end
      end
   end

   initial begin
      int fv [12] = '{8, 8, 0, 9, 7, 15, 0, 8, 3, 12, 7, 15};
      int n;
      for (int k = 0; k < 12; k++) feats[k*4 +: 4] = 4'(fv[k]);
      set_mem(1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 16'(rdy_out), 16'd1);
      chk("rst_valid", 16'(vout), 16'd0);
      chk("rst_req", 16'(req), 16'd0);
      chk("rst_addr1", 16'(a1), 16'd0);
      chk("rst_addr2", 16'(a2), 16'd3);
      chk("rst_addr3", 16'(a3), 16'd7);
      chk("rst_hv1", hv1, 16'h0);
      chk("rst_hv2", hv2, 16'h0);
      chk("rst_hv3", hv3, 16'h0);
      chk("rst_fused", hvf, 16'h0);
      send(3'b111, E_A_ALL, 7, 1'b1);
      send(3'b111, E_A_ALL, 0, 1'b1);
      @(posedge clk); #1 svalid = 3'b101;
      @(negedge clk);
      chk("stall_a1_start", 16'(a1), 16'd1);
      chk("stall_a2_start", 16'(a2), 16'd4);
      chk("stall_a3_start", 16'(a3), 16'd8);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("stall_a1_adv", 16'(a1), 16'd2);
      chk("stall_a2_hold", 16'(a2), 16'd4);
      chk("stall_a3_adv", 16'(a3), 16'd10);
      chk("stall_req", 16'(req), 16'b110);
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("stall_a2_end", 16'(a2), 16'd4);
      @(posedge clk); #1 svalid = 3'b111;
      wait_idle();
      set_mem(1'b1);
      rdy_in = 1'b0;
      send(3'b111, E_B_ALL, 7, 1'b1);
      vin = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("bp_valid", 16'(vout), 16'd1);
         chk("bp_ready_out", 16'(rdy_out), 16'd0);
         chk("bp_hv2", hv2, 16'hFFFF);
         chk("bp_fused", hvf, 16'h00FF);
      end
      @(posedge clk); #1 rdy_in = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("post_done_idle", 16'(rdy_out), 16'd1);
      chk("post_done_req", 16'(req), 16'd0);
      chk("idle_hold_fused", hvf, 16'h00FF);
      vin = 1'b0;
      send(3'b011, E_B_011, 6, 1'b1);
      send(3'b101, E_B_101, 7, 1'b1);
      wait_idle();
      set_mem(1'b0);
      send(3'b010, E_A_010, 6, 1'b1);
      send(3'b000, E_A_ALL, 7, 1'b1);
      wait_idle();
      send(3'b111, E_A_ALL, 0, 1'b0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready", 16'(rdy_out), 16'd1);
      chk("midrst_valid", 16'(vout), 16'd0);
      chk("midrst_req", 16'(req), 16'd0);
      chk("midrst_addr2", 16'(a2), 16'd3);
      chk("midrst_hv1", hv1, 16'h0);
      chk("midrst_fused", hvf, 16'h0);
      send(3'b111, E_A_ALL, 7, 1'b1);
      n = 0;
      while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
      @(negedge clk);
      chk("sb_drained", 16'(sb.size()), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spatial_encoder_param.md
# spatial_encoder_param

Parametrised spatial encoder for the HD sensor-fusion pipeline. It accepts one sample frame of all input channels and encodes up to three modalities, each with its own channel count. Each modality streams item- and projection-memory words from its own SRAM banks and stalls independently of the others. It produces one majority-bundled hypervector per modality plus a fused cross-modality hypervector, which feed the temporal encoder.

## Interface
- HV_DIMENSION, 2000: hypervector width in bits.
- CHANNEL_WIDTH, 4: bits per channel feature, unsigned.
- MOD1_CH, 32: modality 1 channel count, ≥1.
- MOD2_CH, 77: modality 2 channel count, ≥1.
- MOD3_CH, 105: modality 3 channel count, ≥1.
- TOTAL_CH, derived: MOD1_CH+MOD2_CH+MOD3_CH. AW = ceilLog2(TOTAL_CH).
- Clk_CI  in  1  single clock, rising edge.
- Reset_RI  in  1  synchronous, active-high reset.
- ValidIn_SI  in  1  input frame valid.
- ReadyOut_SO  out  1  encoder can accept a frame.
- ChannelsInput_DI  in  CHANNEL_WIDTH*TOTAL_CH  channel k occupies bits [k*CW : k*CW+CW-1], MSB-first indexing.
- ModeEn_SI  in  3  modality enable mask, bit0 = mod1; sampled on frame accept.
- ValidOut_SO  out  1  outputs valid.
- ReadyIn_SI  in  1  downstream accepts outputs.
- SramReq_SO  out  3  per-modality read request.
- SramValid_SI  in  3  per-modality read data valid; covers that modality's IM, ProjNeg and ProjPos banks together.
- Addr_mod1_DO, Addr_mod2_DO, Addr_mod3_DO  out  AW each  global channel index of the current read.
- IM_DI, ProjNeg_DI, ProjPos_DI  in  3*HV_DIMENSION each  item and projection words; modality m occupies slice m-1.
- HypervectorOut_mod1_DO, _mod2_DO, _mod3_DO  out  HV_DIMENSION each  per-modality encoded HV.
- HypervectorFused_DO  out  HV_DIMENSION  fused HV.

## Operation
- FSM states:
  - IDLE: ReadyOut_SO=1. On ValidIn_SI, register all channels and the enable mask, clear the per-modality counters, and go to RUN.
  - RUN: each enabled, unfinished modality asserts SramReq_SO[m].
  - DONE: ValidOut_SO=1. On ReadyIn_SI, go to IDLE.
- A mask of 3'b000 is registered as 3'b111. Disabled modalities never request, count as finished, and output all zeros.
- Addressing. Per-modality local counter c_m. Addresses: Addr_mod1=c_1; Addr_mod2=MOD1_CH+c_2; Addr_mod3=MOD1_CH+MOD2_CH+c_3.
- Consume beat. Modality m consumes a beat in a cycle where SramReq_SO[m] & SramValid_SI[m]. On that beat:
  - Feature f = the registered channel at Addr_mod_m.
  - Projection P = ProjPos if f ≥ 2^(CW-1), else ProjNeg.
  - Bound vector b = IM XOR P.
  - Each bit counter of modality m increments where b=1. Counter width is ceilLog2(MODm_CH+1).
  - c_m increments.
- Modalities advance independently. A stall on one modality never stalls another.
- A modality finishes on the beat where c_m = MODm_CH-1. It then deasserts SramReq_SO[m]; c_m holds.
- RUN → DONE one cycle after every enabled modality has finished. On the DONE entry edge, outputs are computed and registered.
- Per-modality output for bit i, channel count N, count n:
  - If 2n > N: 1.
  - If 2n < N: 0.
  - If 2n = N (even N only): tie bit t_i = b_ch0[i] XOR b_ch1[i]. The bound vectors of local channels 0 and 1 are stored on their beats.
  - If N = 1: output = b_ch0.
- Fused output:
  - 3 enabled: bitwise majority of the three modality outputs.
  - 2 enabled: bitwise OR of the two.
  - 1 enabled: that modality's output.

## Timing
- Reset values:
  - State IDLE.
  - ReadyOut_SO=1 (combinational in IDLE).
  - ValidOut_SO=0, SramReq_SO=0.
  - All HV outputs 0, all counters 0.
  - Addresses equal their base offsets (0, MOD1_CH, MOD1_CH+MOD2_CH).
- Accept edge → SramReq_SO high next cycle.
- With SramValid_SI held high: ValidOut_SO rises max(enabled MODm_CH)+2 cycles after the accept edge.
- HV outputs are registered. They are stable from DONE entry until the next DONE entry, including through IDLE.
- ValidOut_SO stays high until ReadyIn_SI is sampled high. No new frame is accepted while in RUN or DONE.
- SramValid_SI while SramReq_SO[m]=0 is ignored.
- Reset asserted mid-RUN or mid-DONE returns to IDLE next edge with all reset values. The partial frame is discarded.
- ValidIn_SI and ReadyIn_SI high in the same DONE cycle: go to IDLE only. The frame is accepted in IDLE on a later cycle.

## Test plan
- HV_DIMENSION=16, CW=4, CH=3/4/5, all enabled, SramValid tied 1. Stimulus: mod1 features 8,8,0 with IM=0 and ProjPos=ProjNeg=16'hFFFF. Response: mod1 out = 16'hFFFF; ValidOut_SO rises 7 cycles after accept.
- Even-count tie. Mod2 (N=4) with b = 16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00. Response: all bits tie; output = 16'h00FF XOR 16'hFF00 = 16'hFFFF.
- Independent stall. Drop SramValid_SI[1] for 10 cycles mid-frame. Response: mod1 and mod3 addresses keep advancing; mod2 address holds; results are identical to the unstalled run.
- Mask 3'b010. Response: only SramReq_SO[1] toggles; mod1 and mod3 outputs are 0; fused = mod2 output; latency 6 cycles. Mask 3'b000 behaves as 3'b111.
- Backpressure. Hold ReadyIn_SI=0 for 20 cycles in DONE. Response: ValidOut_SO and outputs stable; ReadyOut_SO=0.
- Assert Reset_RI for one cycle mid-RUN. Response: next cycle IDLE, SramReq_SO=0, outputs 0. A following full frame encodes correctly.
